// File: rtl/memdma.sv
// Snooping memory-to-memory DMA: a CPU write to TRIG_ADDR copies one 2^LEN_LOG2-byte page to DST_ADDR.
// Optional one-cycle ALIGN state before the first read is built when MEMDMA_ALIGN_EN is defined.
module memdma #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] DST_ADDR  = 16'h2004,
    parameter int unsigned LEN_LOG2  = 8,
    parameter bit          DST_INC   = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] cpumc_a_in,
    input  logic [7:0]  cpumc_din_in,
    input  logic [7:0]  cpumc_dout_in,
    input  logic        cpu_r_nw_in,
    input  logic        cpumc_rdy_in,
    output logic        active_out,
    output logic        done_out,
    output logic [15:0] cpumc_a_out,
    output logic [7:0]  cpumc_d_out,
    output logic        cpumc_r_nw_out,
    output logic        cpumc_req
);

    typedef enum logic [2:0] {
        StReady    = 3'd0,
`ifdef MEMDMA_ALIGN_EN
        StAlign    = 3'd1,
`endif
        StRdReq    = 3'd2,
        StRdWait   = 3'd3,
        StWrite    = 3'd4,
        StCooldown = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            page_q, page_d;
    logic [LEN_LOG2-1:0]   count_q, count_d;
    logic [7:0]            data_q, data_d;
    logic                  done_q, done_d;
    logic [15:0]           src_addr;
    logic [15:0]           dst_addr;

    // count is exactly LEN_LOG2 bits, so the source address cannot leave the page
    assign src_addr = {page_q, 8'h00} + 16'(count_q);
    assign dst_addr = DST_INC ? DST_ADDR + 16'(count_q) : DST_ADDR;

    always_comb begin
        state_d        = state_q;
        page_d         = page_q;
        count_d        = count_q;
        data_d         = data_q;
        done_d         = 1'b0;
        active_out     = 1'b0;
        cpumc_a_out    = 16'h0000;
        cpumc_d_out    = 8'h00;
        cpumc_r_nw_out = 1'b1;
        cpumc_req      = 1'b0;

        case (state_q)
            StReady: begin
                if (cpumc_a_in == TRIG_ADDR && !cpu_r_nw_in) begin
                    page_d  = cpumc_din_in;
                    count_d = '0;
`ifdef MEMDMA_ALIGN_EN
                    state_d = StAlign;
`else
                    state_d = StRdReq;
`endif
                end
            end
`ifdef MEMDMA_ALIGN_EN
            StAlign: begin
                active_out = 1'b1;
                state_d    = StRdReq;
            end
`endif
            StRdReq: begin
                active_out  = 1'b1;
                cpumc_a_out = src_addr;
                cpumc_req   = 1'b1;
                state_d     = StRdWait;
            end
            StRdWait: begin
                active_out  = 1'b1;
                cpumc_a_out = src_addr;
                data_d      = cpumc_dout_in;
                if (cpumc_rdy_in) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                active_out     = 1'b1;
                cpumc_a_out    = dst_addr;
                cpumc_d_out    = data_q;
                cpumc_r_nw_out = 1'b0;
                if (count_q == '1) begin
                    done_d  = 1'b1;
                    state_d = StCooldown;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = StRdReq;
                end
            end
            StCooldown: begin
                if (cpu_r_nw_in) begin
                    state_d = StReady;
                end
            end
            default: state_d = StReady;
        endcase

        // Reset masks the bus immediately so an in-flight write never reaches memory
        if (rst_in) begin
            active_out     = 1'b0;
            cpumc_a_out    = 16'h0000;
            cpumc_d_out    = 8'h00;
            cpumc_r_nw_out = 1'b1;
            cpumc_req      = 1'b0;
        end
    end

    assign done_out = done_q && !rst_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StReady;
            page_q  <= 8'h00;
            count_q <= '0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            count_q <= count_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_memdma.sv
// Scoreboard bench for memdma: a default-size instance and a 16-byte incrementing-destination
// instance share the snooped CPU bus; each has its own memory responder.
module tb_memdma;

`ifdef MEMDMA_ALIGN_EN
    localparam int ALN = 1;
`else
    localparam int ALN = 0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_din;
    logic        cpu_r_nw;
    logic [7:0]  dout [2];
    logic        rdy [2];
    logic        act [2];
    logic        done [2];
    logic [15:0] a_o [2];
    logic [7:0]  d_o [2];
    logic        rnw_o [2];
    logic        req [2];

    always #5 clk_in = ~clk_in;

    memdma u_dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .cpumc_a_in    (cpu_a),
        .cpumc_din_in  (cpu_din),
        .cpumc_dout_in (dout[0]),
        .cpu_r_nw_in   (cpu_r_nw),
        .cpumc_rdy_in  (rdy[0]),
        .active_out    (act[0]),
        .done_out      (done[0]),
        .cpumc_a_out   (a_o[0]),
        .cpumc_d_out   (d_o[0]),
        .cpumc_r_nw_out(rnw_o[0]),
        .cpumc_req     (req[0])
    );

    memdma #(
        .TRIG_ADDR(16'h4015),
        .DST_ADDR (16'h0300),
        .LEN_LOG2 (4),
        .DST_INC  (1'b1)
    ) u_dut_small (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .cpumc_a_in    (cpu_a),
        .cpumc_din_in  (cpu_din),
        .cpumc_dout_in (dout[1]),
        .cpu_r_nw_in   (cpu_r_nw),
        .cpumc_rdy_in  (rdy[1]),
        .active_out    (act[1]),
        .done_out      (done[1]),
        .cpumc_a_out   (a_o[1]),
        .cpumc_d_out   (d_o[1]),
        .cpumc_r_nw_out(rnw_o[1]),
        .cpumc_req     (req[1])
    );

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    // Memory model: byte 0 of a page can be held off by rdy_delay cycles, all others ready at once
    int wcnt = 0;
    int rdy_delay = 0;
    always @(posedge clk_in) wcnt <= req[0] ? 0 : wcnt + 1;
    assign rdy[0]  = (a_o[0][7:0] == 8'h00) ? (wcnt >= rdy_delay) : 1'b1;
    assign dout[0] = rdy[0] ? mem_fn(a_o[0]) : 8'hEE;
    assign rdy[1]  = 1'b1;
    assign dout[1] = mem_fn(a_o[1]);

    int nvec = 0;
    int nbad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          cyc = 0;
    logic [15:0] exp_rd [2][$];
    logic [23:0] exp_wr [2][$];
    int          act_cnt [2];
    int          done_cnt [2];
    int          wr_seen [2];
    int          req_tot [2];
    int          b0_cyc [2];
    bit   [15:0] cur_src [2];
    bit          prev_req [2];
    int          trig_cyc = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        for (int k = 0; k < 2; k++) begin
            if (act[k]) act_cnt[k]++;
            if (done[k]) done_cnt[k]++;
            if (!act[k]) begin
                check_val("idle_bus", {a_o[k], d_o[k], rnw_o[k], req[k]}, {16'h0, 8'h0, 2'b10});
            end
            if (req[k]) begin
                req_tot[k]++;
                check_val("req_single", 32'(prev_req[k]), 32'd0);
                check_val("rd_pending", 32'(exp_rd[k].size() > 0), 32'd1);
                if (exp_rd[k].size() > 0) check_val("rd_addr", 32'(a_o[k]), 32'(exp_rd[k].pop_front()));
                cur_src[k] = a_o[k];
                if (a_o[k][7:0] == 8'h00) b0_cyc[k] = cyc;
            end else if (act[k] && rnw_o[k] && a_o[k] != 16'h0) begin
                check_val("rd_hold", 32'(a_o[k]), 32'(cur_src[k]));
            end
            if (!rnw_o[k]) begin
                logic [23:0] e;
                check_val("wr_pending", 32'(exp_wr[k].size() > 0), 32'd1);
                if (exp_wr[k].size() > 0) begin
                    e = exp_wr[k].pop_front();
                    check_val("wr_addr", 32'(a_o[k]), 32'(e[23:8]));
                    check_val("wr_data", 32'(d_o[k]), 32'(e[7:0]));
                end
                wr_seen[k]++;
            end
            prev_req[k] = req[k];
        end
    end

    task automatic push_xfer(input int k, input logic [7:0] page, input int n,
                             input logic [15:0] dst, input bit inc);
        for (int i = 0; i < n; i++) begin
            logic [15:0] src;
            src = {page, 8'h00} + 16'(i);
            exp_rd[k].push_back(src);
            exp_wr[k].push_back({inc ? dst + 16'(i) : dst, mem_fn(src)});
        end
    endtask

    // Called just after a rising edge; the write sits on the bus for one full cycle
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input bit hold_w);
        cpu_a    = a;
        cpu_din  = d;
        cpu_r_nw = 1'b0;
        @(posedge clk_in);
        #1;
        trig_cyc = cyc;
        if (hold_w) begin
            cpu_a = 16'h1234;
        end else begin
            cpu_a    = 16'h0000;
            cpu_r_nw = 1'b1;
        end
    endtask

    task automatic wait_done(input int k, input int target, input string tag);
        for (int i = 0; i < 4000 && done_cnt[k] < target; i++) begin
            @(posedge clk_in);
            #1;
        end
        check_val(tag, 32'(done_cnt[k]), 32'(target));
    endtask

    initial begin
        int a0;
        int w0;
        int r0;
        rst_in   = 1'b1;
        cpu_a    = 16'h0000;
        cpu_din  = 8'h00;
        cpu_r_nw = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        check_val("rst_done", 32'({done[0], done[1]}), 32'd0);
        check_val("rst_act", 32'({act[0], act[1]}), 32'd0);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        // 16-byte instance, incrementing destination
        a0 = act_cnt[1];
        w0 = wr_seen[1];
        push_xfer(1, 8'h07, 16, 16'h0300, 1'b1);
        cpu_write(16'h4015, 8'h07, 1'b0);
        wait_done(1, 1, "small_done");
        repeat (20) @(posedge clk_in);
        #1;
        check_val("small_act", 32'(act_cnt[1] - a0), 32'(48 + ALN));
        check_val("small_wr", 32'(wr_seen[1] - w0), 32'd16);
        check_val("small_lat", 32'(b0_cyc[1] - (trig_cyc - 1)), 32'(1 + ALN));
        check_val("small_done_once", 32'(done_cnt[1]), 32'd1);
        check_val("big_quiet", 32'(req_tot[0]), 32'd0);

        // Full page, immediate rdy
        a0 = act_cnt[0];
        w0 = wr_seen[0];
        push_xfer(0, 8'h02, 256, 16'h2004, 1'b0);
        cpu_write(16'h4014, 8'h02, 1'b0);
        wait_done(0, 1, "full_done");
        repeat (10) @(posedge clk_in);
        #1;
        check_val("full_act", 32'(act_cnt[0] - a0), 32'(768 + ALN));
        check_val("full_wr", 32'(wr_seen[0] - w0), 32'd256);
        check_val("full_lat", 32'(b0_cyc[0] - (trig_cyc - 1)), 32'(1 + ALN));
        check_val("full_done_once", 32'(done_cnt[0]), 32'd1);

        // Slow first read, retrigger mid-transfer, CPU keeps writing after the end
        rdy_delay = 5;
        a0 = act_cnt[0];
        push_xfer(0, 8'h02, 256, 16'h2004, 1'b0);
        cpu_write(16'h4014, 8'h02, 1'b1);
        repeat (100) @(posedge clk_in);
        #1;
        cpu_write(16'h4014, 8'h05, 1'b1);
        wait_done(0, 2, "slow_done");
        rdy_delay = 0;
        check_val("slow_act", 32'(act_cnt[0] - a0), 32'(773 + ALN));
        check_val("slow_rd_left", 32'(exp_rd[0].size()), 32'd0);
        cpu_write(16'h4014, 8'h09, 1'b1);
        r0 = req_tot[0];
        repeat (20) @(posedge clk_in);
        #1;
        check_val("cooldown_hold", 32'(req_tot[0] - r0), 32'd0);
        cpu_a    = 16'h0000;
        cpu_r_nw = 1'b1;
        @(posedge clk_in);
        #1;

        // Reset while byte 40 is being written
        push_xfer(0, 8'h04, 256, 16'h2004, 1'b0);
        w0 = wr_seen[0];
        cpu_write(16'h4014, 8'h04, 1'b0);
        for (int i = 0; i < 2000 && !(wr_seen[0] - w0 == 40 && rnw_o[0] == 1'b0); i++) begin
            @(posedge clk_in);
            #1;
        end
        check_val("rst_reach", 32'(wr_seen[0] - w0), 32'd40);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check_val("rst_mid_act", 32'(act[0]), 32'd0);
        exp_rd[0].delete();
        exp_wr[0].delete();
        r0 = req_tot[0];
        repeat (20) @(posedge clk_in);
        #1;
        check_val("rst_no_req", 32'(req_tot[0] - r0), 32'd0);
        check_val("rst_no_wr", 32'(wr_seen[0] - w0), 32'd40);
        check_val("rst_no_done", 32'(done_cnt[0]), 32'd2);

        // Restart after reset begins again at byte 0
        a0 = act_cnt[0];
        push_xfer(0, 8'h03, 256, 16'h2004, 1'b0);
        cpu_write(16'h4014, 8'h03, 1'b0);
        wait_done(0, 3, "restart_done");
        repeat (5) @(posedge clk_in);
        #1;
        check_val("restart_act", 32'(act_cnt[0] - a0), 32'(768 + ALN));
        check_val("restart_wr_left", 32'(exp_wr[0].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
